fp_mul_seq: RTL and testbench
=============================

Name: fp_mul_seq

Overview:
- Parametrised, multi-cycle IEEE-754 binary floating-point multiplier; successor to the combinational single-precision multiplier.
- Generic exponent and fraction widths and a configurable shift-add radix.
- Proper four-mode rounding with guard/round/sticky bits and round-mode-aware overflow saturation.
- Valid/ready handshakes on input and output, so the FPU control path can stall it.
- Sits beside the adder in the FPU datapath.

Parameters:
EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
MAN_W, 23, stored fraction width; significand is MAN_W+1 bits
BPC, 1, multiplier bits consumed per MUL cycle; must divide MAN_W+1; N = (MAN_W+1)/BPC

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operands and mode valid
in_ready  out  1  block can accept operands
a  in  EXP_W+MAN_W+1  operand A
b  in  EXP_W+MAN_W+1  operand B
round_mode  in  2  rounding mode: 00 RNE, 01 RTZ, 10 RUP (toward +inf), 11 RDN (toward -inf)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  EXP_W+MAN_W+1  product
error  out  1  NaN produced (NaN input, or 0*inf)
overflow  out  1  finite overflow, or inf operand times nonzero finite/inf

Behaviour:
- One clock (clk). Reset is synchronous, active-low (rst_n). Sampled only at the rising edge of clk.
- Reset state: IDLE. in_ready=1, out_valid=0. result, error and overflow are all 0. Internal accumulators are cleared.
- A reset asserted mid-operation abandons the operation. No result is emitted.
- FSM states: IDLE, MUL, NORM, ROUND, DONE. in_ready=1 only in IDLE. Only one operation is in flight at a time.
- IDLE: on in_valid&&in_ready, latch a, b and round_mode. Classify the operands:
  - Subnormal inputs (exp==0) are treated as zero.
  - If a special case applies, compute the result directly and go to DONE. Special cases: NaN, inf, zero, or a zero operand.
  - Otherwise go to MUL.
- MUL: per cycle, accumulate BPC partial products (LSB first) into a 2*(MAN_W+1)-bit product. Stay in MUL for exactly N cycles, then go to NORM.
- NORM (1 cycle):
  - Form the exponent as expA+expB-bias in a signed EXP_W+2-bit value.
  - If product MSB=1, take the upper significand and increment the exponent.
  - Extract guard bit G and sticky S (S = OR of all lower bits).
- ROUND (1 cycle): the increment rule depends on the mode.
  - RNE: increment if G&&(S||lsb).
  - RTZ: never increment.
  - RUP: increment if (G||S)&&!sign.
  - RDN: increment if (G||S)&&sign.
  - A significand carry-out renormalises and increments the exponent.
  - If the exponent is ≥ all-ones, overflow=1 and the result saturates by mode: RNE gives ±inf; RTZ gives ±max finite; RUP gives +inf or -max; RDN gives +max or -inf.
  - If the exponent is ≤0, the result is signed zero (flush-to-zero). Go to DONE.
- DONE: out_valid=1. result and flags are held stable until out_ready. On out_valid&&out_ready, go to IDLE. in_ready rises in the next cycle.
- Latency from the accept edge T:
  - Normal path: out_valid is high from edge T+N+3. With defaults this is T+27.
  - Special path: out_valid is high from edge T+1.
- Specials (sign = signA^signB unless stated):
  - Input NaN: propagate A if A is NaN, else B, forced quiet (fraction MSB set). error=1.
  - inf*0: canonical qNaN, i.e. sign 0, exp all ones, fraction MSB only. error=1.
  - inf*nonzero: ±inf. overflow=1.
  - Zero operand: ±0. Both flags 0.
- Flags are 0 for every ordinary result.

Optional Feature:
- Macro FP_MUL_SEQ_FLAGS_EN.
- Defined: adds outputs inexact (1 bit) and underflow (1 bit). Both are valid with result.
  - inexact = G||S on the normal path, or on saturation.
  - underflow = flushed to zero from nonzero operands.
  - Both are 0 on the special path and after reset.
- Not defined: these ports do not exist, and no related logic is synthesised.

Test Plan:
- Basic: defaults, a=0x3FC00000, b=0x40000000, RNE. Expect result=0x40400000, flags 0, out_valid exactly 27 edges after accept.
- Rounding: a=b=0x3F800001. Expect RNE→0x3F800002, RTZ→0x3F800002, RUP→0x3F800003. With a=0xBF800001, b=0x3F800001: RDN→0xBF800003, RUP→0xBF800002.
- Overflow: a=b=0x7F000000. Expect RNE→0x7F800000 with overflow=1, RTZ→0x7F7FFFFF with overflow=1. With a=0xFF000000, b=0x7F000000: RUP→0xFF7FFFFF.
- Specials:
  - a=0x7F800000, b=0x00000000 → 0x7FC00000, error=1, out_valid at T+1.
  - a=0x7FA00000 → 0x7FE00000, error=1.
  - a=0x00400000 (subnormal), b=0x3F800000 → 0x00000000.
- Handshake: hold out_ready=0 for 5 cycles in DONE. Expect result stable and in_ready=0. New in_valid is ignored until one cycle after out_ready.
- Reset and parameters:
  - rst_n=0 during MUL cycle 10 → next edge: out_valid=0, in_ready=1. No result is emitted.
  - Rerun the basic case with BPC=4 → latency T+9.
  - Rerun with EXP_W=11, MAN_W=52 on 1.5*2.0 → 0x4008000000000000.

Source files
------------

// File: rtl/fp_mul_seq.sv
// fp_mul_seq: multi-cycle IEEE-754 multiplier, radix-2^BPC shift-add, 4-mode rounding, valid/ready.
// Optional inexact/underflow outputs are enabled by defining FP_MUL_SEQ_FLAGS_EN.
module fp_mul_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BPC = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic [1:0]             round_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   error,
  output logic                   overflow
`ifdef FP_MUL_SEQ_FLAGS_EN
  ,
  output logic                   inexact,
  output logic                   underflow
`endif
);
  localparam int W = EXP_W + MAN_W + 1;
  localparam int SW = MAN_W + 1;
  localparam int N = SW / BPC;
  localparam int CW = $clog2(N + 1);
  localparam int EW = EXP_W + 2;
  localparam logic [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [EXP_W-1:0] EMAXM = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [MAN_W-1:0] QF = {1'b1, {(MAN_W-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, MUL, NORM, ROUND, DONE} state_t;
  state_t state, state_nx;
  logic [SW-1:0] ma, sig, sig_n, sig_r;
  logic [2*SW-1:0] prod, prod_nx;
  logic [SW+BPC-1:0] pp, sum;
  logic [2*SW+BPC-1:0] wide;
  logic [CW-1:0] cnt;
  logic [1:0] rm;
  logic sgn, g, s, g_n, s_n, msb, inc, sat, flush, to_inf;
  logic signed [EW-1:0] ex, ex_in, ex_n, ex_r;
  logic [SW:0] rs;
  logic [EXP_W-1:0] ea, eb;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, inv, special, s_in;
  logic [W-1:0] sp_res, rnd_res;
  assign ea = a[W-2:MAN_W];
  assign eb = b[W-2:MAN_W];
  always_comb begin
    s_in = a[W-1] ^ b[W-1];
    a_nan = &ea && |a[MAN_W-1:0];
    b_nan = &eb && |b[MAN_W-1:0];
    a_inf = &ea && !(|a[MAN_W-1:0]);
    b_inf = &eb && !(|b[MAN_W-1:0]);
    // exponent zero covers subnormals, which are flushed to zero on input
    a_zero = ~|ea;
    b_zero = ~|eb;
    inv = (a_inf && b_zero) || (a_zero && b_inf);
    special = a_nan || b_nan || a_inf || b_inf || a_zero || b_zero;
    sp_res = a_nan ? (a | {1'b0, {EXP_W{1'b0}}, QF}) :
             b_nan ? (b | {1'b0, {EXP_W{1'b0}}, QF}) :
             inv ? {1'b0, EMAX, QF} :
             (a_inf || b_inf) ? {s_in, EMAX, {MAN_W{1'b0}}} : {s_in, {(EXP_W+MAN_W){1'b0}}};
    ex_in = $signed({2'b00, ea}) + $signed({2'b00, eb}) - $signed(BIAS);
    pp = (SW+BPC)'(ma) * (SW+BPC)'(prod[BPC-1:0]);
    sum = {{BPC{1'b0}}, prod[2*SW-1:SW]} + pp;
    wide = {sum, prod[SW-1:0]};
    prod_nx = wide[2*SW+BPC-1:BPC];
    msb = prod[2*SW-1];
    sig_n = msb ? prod[2*SW-1:SW] : prod[2*SW-2:SW-1];
    g_n = msb ? prod[SW-1] : prod[SW-2];
    s_n = msb ? |prod[SW-2:0] : |prod[SW-3:0];
    ex_n = ex + $signed({{(EW-1){1'b0}}, msb});
    inc = (rm == 2'd0) ? (g && (s || sig[0])) :
          (rm == 2'd1) ? 1'b0 :
          (rm == 2'd2) ? ((g || s) && !sgn) : ((g || s) && sgn);
    rs = {1'b0, sig} + {{SW{1'b0}}, inc};
    ex_r = ex + $signed({{(EW-1){1'b0}}, rs[SW]});
    sig_r = rs[SW] ? rs[SW:1] : rs[SW-1:0];
    sat = !ex_r[EW-1] && (ex_r[EW-2:0] >= {1'b0, EMAX});
    flush = ex_r[EW-1] || (ex_r == '0);
    to_inf = (rm == 2'd0) || (rm == 2'd2 && !sgn) || (rm == 2'd3 && sgn);
    rnd_res = sat ? (to_inf ? {sgn, EMAX, {MAN_W{1'b0}}} : {sgn, EMAXM, {MAN_W{1'b1}}}) :
              flush ? {sgn, {(EXP_W+MAN_W){1'b0}}} : {sgn, ex_r[EXP_W-1:0], sig_r[MAN_W-1:0]};
  end
  always_comb begin
    state_nx = state;
    in_ready = (state == IDLE);
    out_valid = (state == DONE);
    case (state)
      IDLE: state_nx = in_valid ? (special ? DONE : MUL) : IDLE;
      MUL: state_nx = (cnt == CW'(N - 1)) ? NORM : MUL;
      NORM: state_nx = ROUND;
      ROUND: state_nx = DONE;
      DONE: state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ma <= '0;
      prod <= '0;
      cnt <= '0;
      rm <= '0;
      sgn <= 1'b0;
      ex <= '0;
      sig <= '0;
      g <= 1'b0;
      s <= 1'b0;
      result <= '0;
      error <= 1'b0;
      overflow <= 1'b0;
`ifdef FP_MUL_SEQ_FLAGS_EN
      inexact <= 1'b0;
      underflow <= 1'b0;
`endif
    end else if (state == IDLE) begin
      if (in_valid) begin
        ma <= {1'b1, a[MAN_W-1:0]};
        prod <= {{SW{1'b0}}, 1'b1, b[MAN_W-1:0]};
        cnt <= '0;
        rm <= round_mode;
        sgn <= s_in;
        ex <= ex_in;
        if (special) begin
          result <= sp_res;
          error <= a_nan || b_nan || inv;
          overflow <= !(a_nan || b_nan || inv) && (a_inf || b_inf);
`ifdef FP_MUL_SEQ_FLAGS_EN
          inexact <= 1'b0;
          underflow <= 1'b0;
`endif
        end
      end
    end else if (state == MUL) begin
      prod <= prod_nx;
      cnt <= cnt + 1'b1;
    end else if (state == NORM) begin
      sig <= sig_n;
      g <= g_n;
      s <= s_n;
      ex <= ex_n;
    end else if (state == ROUND) begin
      result <= rnd_res;
      error <= 1'b0;
      overflow <= sat;
`ifdef FP_MUL_SEQ_FLAGS_EN
      inexact <= g || s || sat;
      underflow <= flush;
`endif
    end
  end
endmodule

// File: tb/tb_fp_mul_seq.sv
// tb_fp_mul_seq: directed vector table plus handshake, reset and parameter-variant sequences.
module tb_fp_mul_seq;
  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, out_valid, out_ready, error, overflow;
  logic [31:0] op_a, op_b, result;
  logic [1:0] rmode;
  logic v4, ir4, ov4, e4, o4;
  logic [31:0] a4, b4, r4;
  logic [1:0] rm4;
  logic v64, ir64, ov64, e64, o64;
  logic [63:0] a64, b64, r64;
  logic [1:0] rm64;
  int n_cmp = 0;
  int n_bad = 0;

  fp_mul_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(op_a), .b(op_b),
    .round_mode(rmode), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .error(error), .overflow(overflow)
  );
  fp_mul_seq #(.BPC(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(ir4), .a(a4), .b(b4),
    .round_mode(rm4), .out_valid(ov4), .out_ready(1'b1), .result(r4),
    .error(e4), .overflow(o4)
  );
  fp_mul_seq #(.EXP_W(11), .MAN_W(52)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(ir64), .a(a64), .b(b64),
    .round_mode(rm64), .out_valid(ov64), .out_ready(1'b1), .result(r64),
    .error(e64), .overflow(o64)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] a, b;
    logic [1:0] rm;
    logic [31:0] res;
    logic err, ovf;
    int lat;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input vec_t t, input int idx);
    int lat;
    @(negedge clk);
    op_a = t.a; op_b = t.b; rmode = t.rm; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat);
    check($sformatf("v%0d_lat", idx), 64'(lat), 64'(t.lat));
    check($sformatf("v%0d_res", idx), {32'b0, result}, {32'b0, t.res});
    check($sformatf("v%0d_err", idx), {63'b0, error}, {63'b0, t.err});
    check($sformatf("v%0d_ovf", idx), {63'b0, overflow}, {63'b0, t.ovf});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_aux(input bit dp, input logic [63:0] x, input logic [63:0] y, input logic [1:0] rm,
                         input logic [63:0] exp_res, input int exp_lat, input string nm);
    int lat;
    logic [63:0] got;
    @(negedge clk);
    if (dp) begin a64 = x; b64 = y; rm64 = rm; v64 = 1'b1; end
    else begin a4 = x[31:0]; b4 = y[31:0]; rm4 = rm; v4 = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    v4 = 1'b0; v64 = 1'b0;
    lat = 1;
    while (!(dp ? ov64 : ov4) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    got = dp ? r64 : {32'b0, r4};
    check({nm, "_res"}, got, exp_res);
    check({nm, "_lat"}, 64'(lat), 64'(exp_lat));
    @(negedge clk);
  endtask

  vec_t vt[29];
  int lat, seen;

  initial begin
    vt[0]  = '{32'h3FC00000, 32'h40000000, 2'd0, 32'h40400000, 1'b0, 1'b0, 27};
    vt[1]  = '{32'h3F800001, 32'h3F800001, 2'd0, 32'h3F800002, 1'b0, 1'b0, 27};
    vt[2]  = '{32'h3F800001, 32'h3F800001, 2'd1, 32'h3F800002, 1'b0, 1'b0, 27};
    vt[3]  = '{32'h3F800001, 32'h3F800001, 2'd2, 32'h3F800003, 1'b0, 1'b0, 27};
    vt[4]  = '{32'hBF800001, 32'h3F800001, 2'd3, 32'hBF800003, 1'b0, 1'b0, 27};
    vt[5]  = '{32'hBF800001, 32'h3F800001, 2'd2, 32'hBF800002, 1'b0, 1'b0, 27};
    vt[6]  = '{32'h7F000000, 32'h7F000000, 2'd0, 32'h7F800000, 1'b0, 1'b1, 27};
    vt[7]  = '{32'h7F000000, 32'h7F000000, 2'd1, 32'h7F7FFFFF, 1'b0, 1'b1, 27};
    vt[8]  = '{32'hFF000000, 32'h7F000000, 2'd2, 32'hFF7FFFFF, 1'b0, 1'b1, 27};
    vt[9]  = '{32'hFF000000, 32'h7F000000, 2'd3, 32'hFF800000, 1'b0, 1'b1, 27};
    vt[10] = '{32'h7F800000, 32'h00000000, 2'd0, 32'h7FC00000, 1'b1, 1'b0, 1};
    vt[11] = '{32'h7FA00000, 32'h3F800000, 2'd0, 32'h7FE00000, 1'b1, 1'b0, 1};
    vt[12] = '{32'h00400000, 32'h3F800000, 2'd0, 32'h00000000, 1'b0, 1'b0, 1};
    vt[13] = '{32'h7F800000, 32'h40000000, 2'd0, 32'h7F800000, 1'b0, 1'b1, 1};
    vt[14] = '{32'h80000000, 32'hFF800000, 2'd0, 32'h7FC00000, 1'b1, 1'b0, 1};
    vt[15] = '{32'h7F800001, 32'h7FC00000, 2'd0, 32'h7FC00001, 1'b1, 1'b0, 1};
    vt[16] = '{32'h3F800000, 32'hFFC00001, 2'd0, 32'hFFC00001, 1'b1, 1'b0, 1};
    vt[17] = '{32'h3FC00000, 32'h3F800001, 2'd0, 32'h3FC00002, 1'b0, 1'b0, 27};
    vt[18] = '{32'h3FC00000, 32'h3F800003, 2'd0, 32'h3FC00004, 1'b0, 1'b0, 27};
    vt[19] = '{32'h3FFFFFFE, 32'h3F800001, 2'd0, 32'h40000000, 1'b0, 1'b0, 27};
    vt[20] = '{32'h3FFFFFFE, 32'h3F800001, 2'd1, 32'h3FFFFFFF, 1'b0, 1'b0, 27};
    vt[21] = '{32'h7F7FFFFF, 32'h3F800001, 2'd0, 32'h7F800000, 1'b0, 1'b1, 27};
    vt[22] = '{32'h7F7FFFFF, 32'h3F800001, 2'd1, 32'h7F7FFFFF, 1'b0, 1'b1, 27};
    vt[23] = '{32'h3F000000, 32'h00800000, 2'd0, 32'h00000000, 1'b0, 1'b0, 27};
    vt[24] = '{32'h3F800000, 32'h00800000, 2'd0, 32'h00800000, 1'b0, 1'b0, 27};
    vt[25] = '{32'h80800000, 32'h00800000, 2'd2, 32'h80000000, 1'b0, 1'b0, 27};
    vt[26] = '{32'hC0000000, 32'h40400000, 2'd0, 32'hC0C00000, 1'b0, 1'b0, 27};
    vt[27] = '{32'h7F000000, 32'h40000000, 2'd1, 32'h7F7FFFFF, 1'b0, 1'b1, 27};
    vt[28] = '{32'h7F000000, 32'h3F800000, 2'd0, 32'h7F000000, 1'b0, 1'b0, 27};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0; rmode = '0;
    v4 = 1'b0; a4 = '0; b4 = '0; rm4 = '0;
    v64 = 1'b0; a64 = '0; b64 = '0; rm64 = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {63'b0, in_ready}, 64'd1);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_result", {32'b0, result}, 64'd0);
    check("rst_error", {63'b0, error}, 64'd0);
    check("rst_overflow", {63'b0, overflow}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 29; i++) run_op(vt[i], i);

    // result must stay put while the consumer stalls, and a waiting operand must not sneak in
    @(negedge clk);
    op_a = 32'h3FC00000; op_b = 32'h40000000; rmode = 2'd0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat);
    check("hold_lat", 64'(lat), 64'd27);
    op_a = 32'h40000000; op_b = 32'h40000000; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d_res", i), {32'b0, result}, 64'h40400000);
      check($sformatf("hold%0d_in_ready", i), {63'b0, in_ready}, 64'd0);
      check($sformatf("hold%0d_out_valid", i), {63'b0, out_valid}, 64'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_out_valid", {63'b0, out_valid}, 64'd0);
    check("release_in_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat);
    check("second_lat", 64'(lat), 64'd27);
    check("second_res", {32'b0, result}, 64'h40800000);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // reset in the middle of MUL abandons the operation
    @(negedge clk);
    op_a = 32'h3FC00000; op_b = 32'h40000000; rmode = 2'd0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    check("midrst_in_ready", {63'b0, in_ready}, 64'd1);
    check("midrst_result", {32'b0, result}, 64'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst_no_result", 64'(seen), 64'd0);
    vt[0].lat = 27;
    run_op(vt[0], 100);

    run_aux(1'b0, 64'h3FC00000, 64'h40000000, 2'd0, 64'h40400000, 9, "bpc4_basic");
    run_aux(1'b0, 64'h3F800001, 64'h3F800001, 2'd2, 64'h3F800003, 9, "bpc4_rup");
    run_aux(1'b0, 64'h7F000000, 64'h7F000000, 2'd1, 64'h7F7FFFFF, 9, "bpc4_sat");
    run_aux(1'b0, 64'h7F800000, 64'h00000000, 2'd0, 64'h7FC00000, 1, "bpc4_inv");
    run_aux(1'b1, 64'h3FF8000000000000, 64'h4000000000000000, 2'd0, 64'h4008000000000000, 56, "dp_basic");
    run_aux(1'b1, 64'h3FF0000000000001, 64'h3FF0000000000001, 2'd2, 64'h3FF0000000000003, 56, "dp_rup");
    run_aux(1'b1, 64'h3FF0000000000001, 64'h3FF0000000000001, 2'd0, 64'h3FF0000000000002, 56, "dp_rne");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
